inst_queue_ctrl: RTL and testbench
==================================

INST_QUEUE_CTRL -- requirements
Module: inst_queue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries (power of two, >=8).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port flush, input, 1, discards all queued instructions.
REQ-005 SHALL have port fetch_valid, input, 1, fetch group offered.
REQ-006 SHALL have port fetch_cnt, input, 3, number of instructions in the offered group (1..4).
REQ-007 SHALL have port fetch_inst, input, 128, group payload; oldest instruction in [31:0], then [63:32], [95:64], [127:96].
REQ-008 SHALL have port fetch_ready, output, 1, queue can accept a full 4-instruction group.
REQ-009 SHALL have port disp_cnt, input, 3, instructions consumed by dispatch this cycle (0..4).
REQ-010 SHALL have port dec_inst_en, output, 1, decoder enable; drives the decoder inst_en.
REQ-011 SHALL have ports dec_inst1..dec_inst4, output, 32 each, the four oldest queued instructions; they drive decoder Inst1..Inst4.
REQ-012 SHALL have port dec_valid, output, 4, per-slot valid; bit i covers dec_inst(i+1).
REQ-013 SHALL have port count, output, log2(DEPTH)+1, current occupancy.

Function
REQ-014 SHALL implement a circular buffer with head and tail pointers of log2(DEPTH) bits; pointers wrap modulo DEPTH.
REQ-015 SHALL drive fetch_ready = 1 when registered count <= DEPTH-4, regardless of disp_cnt in the same cycle.
REQ-016 SHALL treat an enqueue as accepted only when fetch_valid && fetch_ready && !flush.
REQ-017 SHALL, on an accepted enqueue, write fetch_cnt words in order to mem[tail], mem[tail+1], ... and advance tail by fetch_cnt.
REQ-018 SHALL treat fetch_cnt = 0 as no enqueue and clamp fetch_cnt > 4 to 4.
REQ-019 SHALL compute dequeue amount deq = min(disp_cnt, count, 4), then advance head by deq.
REQ-020 SHALL update count <= count + enq_cnt - deq when enqueue and dequeue occur in the same cycle.
REQ-021 SHALL drive dec_inst(i+1) = mem[head+i] (modulo DEPTH) combinationally from registered state when i < count.
REQ-022 SHALL drive dec_inst(i+1) = 32'h0 when i >= count.
REQ-023 SHALL drive dec_valid[i] = (i < count) and dec_inst_en = (count != 0).
REQ-024 SHALL give an instruction enqueued at edge N its first appearance on the dec outputs after edge N; fetch-to-decode latency is 1 cycle.
REQ-025 SHALL present a newly written instruction behind older ones only, preserving program order across the wrap boundary.
REQ-026 SHALL, on flush = 1 at an edge, set head = tail = count = 0 and ignore same-cycle fetch and disp_cnt.
REQ-027 SHALL leave the storage array contents unaffected by flush; the outputs are masked through count.
REQ-028 SHALL never overflow; fetch_ready guarantees room for 4 instructions.
REQ-029 SHALL never underflow; the clamp in REQ-019 applies.

Reset
REQ-030 SHALL, while rst_n = 0 and independent of clk, hold head = 0, tail = 0, count = 0, dec_inst_en = 0, dec_valid = 4'b0000, dec_inst1..4 = 32'h0 and fetch_ready = 1.
REQ-031 SHALL leave the storage array unreset.
REQ-032 SHALL, when reset is asserted mid-operation, discard all queued instructions.
REQ-033 SHALL accept an enqueue at the first rising edge after rst_n deasserts.

Verification
REQ-034 SHALL cover this scenario: reset, then a single group with fetch_cnt = 4 of A0..A3 and disp_cnt = 0 -> next cycle dec_inst1..4 = A0..A3, dec_valid = 4'b1111, count = 4, fetch_ready = 1.
REQ-035 SHALL cover this scenario: enqueue 4 and 4 with no dispatch -> count = 8, fetch_ready = 0; then a further fetch_valid is dropped and count stays 8.
REQ-036 SHALL cover this scenario: count = 3 holding B0..B2, disp_cnt = 4 -> deq = 3, count = 0, dec_valid = 0, dec_inst1 = 32'h0, dec_inst_en = 0.
REQ-037 SHALL cover this scenario: head = 6 with 2 queued (C0, C1), enqueue of 3 (C2..C4) plus disp_cnt = 1 -> count = 4, dec_inst1..4 = C1..C4, demonstrating wrap-around.
REQ-038 SHALL cover this scenario: count = 5, flush with fetch_valid = 1 and fetch_cnt = 4 -> count = 0, dec_valid = 0, fetch_ready = 1, and no entries are written.
REQ-039 SHALL cover this scenario: rst_n driven low between clock edges with count = 6 -> outputs reach their reset values immediately without waiting for clk.

Source files
------------

// File: rtl/inst_queue_ctrl.sv
// Instruction queue between fetch and decode: circular buffer that takes up to
// four instructions per cycle and presents the four oldest to the decoder.
module inst_queue_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     fetch_valid,
    input  logic [2:0]               fetch_cnt,
    input  logic [127:0]             fetch_inst,
    output logic                     fetch_ready,
    input  logic [2:0]               disp_cnt,
    output logic                     dec_inst_en,
    output logic [31:0]              dec_inst1,
    output logic [31:0]              dec_inst2,
    output logic [31:0]              dec_inst3,
    output logic [31:0]              dec_inst4,
    output logic [3:0]               dec_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [31:0]   mem [DEPTH];

    logic          enq;
    logic [2:0]    enq_cnt;
    logic [2:0]    disp_lim;
    logic [2:0]    deq_cnt;
    logic [AW-1:0] wr_idx [4];
    logic [AW-1:0] rd_idx [4];
    logic [31:0]   rd_data [4];

    // Readiness looks only at registered occupancy so a same-cycle dispatch
    // never creates a combinational path from dispatch back to fetch.
    always_comb fetch_ready = (count <= CW'(DEPTH - 4));

    always_comb begin
        enq_cnt  = (fetch_cnt > 3'd4) ? 3'd4 : fetch_cnt;
        enq      = fetch_valid && fetch_ready && !flush && (enq_cnt != 3'd0);
        disp_lim = (disp_cnt > 3'd4) ? 3'd4 : disp_cnt;
        deq_cnt  = (CW'(disp_lim) > count) ? count[2:0] : disp_lim;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wr_idx[i] = tail + AW'(i);
            rd_idx[i] = head + AW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + AW'(enq_cnt);
            end
            head  <= head + AW'(deq_cnt);
            count <= count + (enq ? CW'(enq_cnt) : CW'(0)) - CW'(deq_cnt);
        end
    end

    // Storage is deliberately left unreset; stale entries are hidden by count.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < enq_cnt) begin
                    mem[wr_idx[i]] <= fetch_inst[32*i +: 32];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dec_valid[i] = (CW'(i) < count);
            rd_data[i]   = (CW'(i) < count) ? mem[rd_idx[i]] : 32'h0;
        end
        dec_inst_en = (count != '0);
    end

    assign dec_inst1 = rd_data[0];
    assign dec_inst2 = rd_data[1];
    assign dec_inst3 = rd_data[2];
    assign dec_inst4 = rd_data[3];

endmodule

// File: tb/tb_inst_queue_ctrl.sv
// Directed bench for inst_queue_ctrl: stimulus pushes hand-computed expectations
// into a scoreboard queue, a monitor pops and compares after each clock edge.
module tb_inst_queue_ctrl;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         fetch_valid;
    logic [2:0]   fetch_cnt;
    logic [127:0] fetch_inst;
    logic         fetch_ready;
    logic [2:0]   disp_cnt;
    logic         dec_inst_en;
    logic [31:0]  dec_inst1;
    logic [31:0]  dec_inst2;
    logic [31:0]  dec_inst3;
    logic [31:0]  dec_inst4;
    logic [3:0]   dec_valid;
    logic [3:0]   count;

    inst_queue_ctrl #(.DEPTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_cnt   (fetch_cnt),
        .fetch_inst  (fetch_inst),
        .fetch_ready (fetch_ready),
        .disp_cnt    (disp_cnt),
        .dec_inst_en (dec_inst_en),
        .dec_inst1   (dec_inst1),
        .dec_inst2   (dec_inst2),
        .dec_inst3   (dec_inst3),
        .dec_inst4   (dec_inst4),
        .dec_valid   (dec_valid),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        int           cnt;
        logic [127:0] insts;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] ins(input logic [7:0] tag, input int k);
        return {tag, 8'h00, 16'(k)};
    endfunction

    function automatic logic [127:0] grp(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input string nm, input int cnt, input logic [127:0] insts);
        exp_t e;
        e.name  = nm;
        e.cnt   = cnt;
        e.insts = insts;
        sb.push_back(e);
    endtask

    // Monitor: outputs depend only on registered state, so sampling 1 time unit
    // after a falling clock or reset edge is well clear of any update.
    initial begin
        exp_t e;
        logic [3:0] ev;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                for (int k = 0; k < 4; k++) ev[k] = (k < e.cnt);
                cmp({e.name, " count"}, 128'(count), 128'(e.cnt));
                cmp({e.name, " dec_valid"}, 128'(dec_valid), 128'(ev));
                cmp({e.name, " dec_inst_en"}, 128'(dec_inst_en), 128'(e.cnt != 0));
                cmp({e.name, " fetch_ready"}, 128'(fetch_ready), 128'(e.cnt <= 4));
                cmp({e.name, " dec_inst"}, {dec_inst4, dec_inst3, dec_inst2, dec_inst1}, e.insts);
            end
        end
    end

    task automatic step(input string nm, input logic fl, input logic fv, input logic [2:0] fc,
                        input logic [127:0] fi, input logic [2:0] dc,
                        input int ecnt, input logic [127:0] einsts);
        @(negedge clk);
        flush       = fl;
        fetch_valid = fv;
        fetch_cnt   = fc;
        fetch_inst  = fi;
        disp_cnt    = dc;
        @(posedge clk);
        #1;
        push_exp(nm, ecnt, einsts);
    endtask

    localparam logic [31:0] Z = 32'h0;
    localparam logic [31:0] X = 32'hDEAD_BEEF;

    initial begin
        flush       = 1'b0;
        fetch_valid = 1'b0;
        fetch_cnt   = 3'd0;
        fetch_inst  = '0;
        disp_cnt    = 3'd0;
        rst_n       = 1'b1;
        #2;
        push_exp("reset", 0, '0);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        step("a4",   0, 1, 3'd4, grp(ins(8'hA0,0), ins(8'hA0,1), ins(8'hA0,2), ins(8'hA0,3)), 3'd0,
             4, grp(ins(8'hA0,0), ins(8'hA0,1), ins(8'hA0,2), ins(8'hA0,3)));
        step("a8",   0, 1, 3'd4, grp(ins(8'hA0,4), ins(8'hA0,5), ins(8'hA0,6), ins(8'hA0,7)), 3'd0,
             8, grp(ins(8'hA0,0), ins(8'hA0,1), ins(8'hA0,2), ins(8'hA0,3)));
        step("drop", 0, 1, 3'd4, grp(X, X, X, X), 3'd0,
             8, grp(ins(8'hA0,0), ins(8'hA0,1), ins(8'hA0,2), ins(8'hA0,3)));
        step("deq4", 0, 0, 3'd0, '0, 3'd4,
             4, grp(ins(8'hA0,4), ins(8'hA0,5), ins(8'hA0,6), ins(8'hA0,7)));
        step("deq4b", 0, 0, 3'd0, '0, 3'd4, 0, '0);
        step("b3",   0, 1, 3'd3, grp(ins(8'hB0,0), ins(8'hB0,1), ins(8'hB0,2), X), 3'd0,
             3, grp(ins(8'hB0,0), ins(8'hB0,1), ins(8'hB0,2), Z));
        step("deq_clamp", 0, 0, 3'd0, '0, 3'd4, 0, '0);
        step("d3",   0, 1, 3'd3, grp(ins(8'hD0,0), ins(8'hD0,1), ins(8'hD0,2), X), 3'd0,
             3, grp(ins(8'hD0,0), ins(8'hD0,1), ins(8'hD0,2), Z));
        step("d_deq", 0, 0, 3'd0, '0, 3'd3, 0, '0);
        step("c2",   0, 1, 3'd2, grp(ins(8'hC0,0), ins(8'hC0,1), X, X), 3'd0,
             2, grp(ins(8'hC0,0), ins(8'hC0,1), Z, Z));
        step("wrap", 0, 1, 3'd3, grp(ins(8'hC0,2), ins(8'hC0,3), ins(8'hC0,4), X), 3'd1,
             4, grp(ins(8'hC0,1), ins(8'hC0,2), ins(8'hC0,3), ins(8'hC0,4)));
        step("fc0",  0, 1, 3'd0, grp(X, X, X, X), 3'd0,
             4, grp(ins(8'hC0,1), ins(8'hC0,2), ins(8'hC0,3), ins(8'hC0,4)));
        step("clamp7", 0, 1, 3'd7, grp(ins(8'hE0,0), ins(8'hE0,1), ins(8'hE0,2), ins(8'hE0,3)), 3'd2,
             6, grp(ins(8'hC0,3), ins(8'hC0,4), ins(8'hE0,0), ins(8'hE0,1)));
        step("c5",   0, 0, 3'd0, '0, 3'd1,
             5, grp(ins(8'hC0,4), ins(8'hE0,0), ins(8'hE0,1), ins(8'hE0,2)));
        step("flush", 1, 1, 3'd4, grp(ins(8'hF0,0), ins(8'hF0,1), ins(8'hF0,2), ins(8'hF0,3)), 3'd2,
             0, '0);
        step("g2",   0, 1, 3'd2, grp(ins(8'h60,0), ins(8'h60,1), X, X), 3'd0,
             2, grp(ins(8'h60,0), ins(8'h60,1), Z, Z));
        step("g6",   0, 1, 3'd4, grp(ins(8'h60,2), ins(8'h60,3), ins(8'h60,4), ins(8'h60,5)), 3'd0,
             6, grp(ins(8'h60,0), ins(8'h60,1), ins(8'h60,2), ins(8'h60,3)));

        // Asynchronous reset asserted between clock edges with six entries queued.
        @(negedge clk);
        fetch_valid = 1'b0;
        fetch_cnt   = 3'd0;
        disp_cnt    = 3'd0;
        flush       = 1'b0;
        #2;
        push_exp("async_rst", 0, '0);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        step("j4",   0, 1, 3'd4, grp(ins(8'h70,0), ins(8'h70,1), ins(8'h70,2), ins(8'h70,3)), 3'd0,
             4, grp(ins(8'h70,0), ins(8'h70,1), ins(8'h70,2), ins(8'h70,3)));

        @(negedge clk);
        fetch_valid = 1'b0;
        for (int w = 0; w < 5 && sb.size() != 0; w++) begin
            @(negedge clk);
            #2;
        end
        #2;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
